load_store_unit: RTL and testbench

//  Sits between datapath (ALU address / rt data) and word-only data memory (4096 x 32, mem_read/mem_write).

---
 rtl/lsu_pkg.sv | 19 +
 rtl/lsu_if.sv | 29 ++
 rtl/lsu_lane_mux.sv | 42 ++++
 rtl/load_store_unit.sv | 129 ++++++++++++
 tb/tb_load_store_unit.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants for the load/store unit
// Holds the access size encodings, FSM state codes and the default data
// memory size used by load_store_unit and lsu_lane_mux.
package lsu_pkg;
    localparam int unsigned MEM_BYTES_DEF = 16384;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef logic [2:0] state_t;
    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_LOAD   = 3'd1;
    localparam state_t S_RMW_RD = 3'd2;
    localparam state_t S_RMW_WR = 3'd3;
    localparam state_t S_ST_WR  = 3'd4;
    localparam state_t S_RESP   = 3'd5;
endpackage

// File: rtl/lsu_if.sv
// lsu_if: request/response handshake between datapath and load/store unit
// Ports (signals):
//   req_valid/req_ready      request handshake, accept when both high on posedge
//   req_write/size/signed    access kind, size (00 b, 01 h, 10 w, 11 rsvd), load extension
//   req_addr/req_wdata       byte address, store data (low bits used for b/h)
//   resp_valid/err/rdata     one-cycle completion pulse with error flag and load data
// master = datapath side, slave = load/store unit side.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata
    );
endinterface

// File: rtl/lsu_lane_mux.sv
// lsu_lane_mux: little-endian byte/half lane extract and merge
// Ports:
//   addr_lo_i  in  2   low address bits selecting the lane
//   size_i     in  2   access size
//   signed_i   in  1   sign-extend loads
//   rword_i    in  32  word read from memory
//   wdata_i    in  32  store data, byte/half in the low bits
//   ld_data_o  out 32  extracted and extended load value
//   st_word_o  out 32  rword_i with the addressed lane(s) replaced by wdata_i
// Halves are selected by addr_lo_i[1] only, so addr_lo_i[0] is ignored for them.
module lsu_lane_mux
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] rword_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] st_word_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rword_i[{addr_lo_i, 3'b000} +: 8];
    assign half_sel = rword_i[{addr_lo_i[1], 4'b0000} +: 16];

    assign ld_data_o = (size_i == SZ_BYTE) ? {{24{signed_i & byte_sel[7]}}, byte_sel} :
                       (size_i == SZ_HALF) ? {{16{signed_i & half_sel[15]}}, half_sel} :
                       rword_i;

    always_comb begin
        st_word_o = wdata_i;
        if (size_i == SZ_BYTE) begin
            st_word_o = rword_i;
            st_word_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
        end else if (size_i == SZ_HALF) begin
            st_word_o = rword_i;
            st_word_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
        end
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word loads and stores over a word-only data memory
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   bus (lsu_if)     request/response handshake, slave side
//   mem_read         memory read strobe
//   mem_write        memory write strobe, sampled on posedge clk
//   mem_address      word-aligned address {addr[31:2],2'b00}
//   mem_write_data   full word to write
//   mem_read_data    combinational read data from memory
// Build option: LSU_ALIGN_CHECK_EN flags misaligned half/word accesses as errors.
// Sub-word stores read the word, merge the addressed lanes, then write it back.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEF,
    parameter int unsigned DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    lsu_if.slave              bus,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);
    state_t            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] merge_q, merge_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              write_q, write_d;
    logic              misalign;
    logic              req_err;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] st_word;

`ifdef LSU_ALIGN_CHECK_EN
    assign misalign = (bus.req_size == SZ_HALF && bus.req_addr[0]) ||
                      (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign req_err = (bus.req_size == SZ_RSVD) || (bus.req_addr >= MEM_BYTES) || misalign;

    lsu_lane_mux u_lane_mux (
        .addr_lo_i (addr_q[1:0]),
        .size_i    (size_q),
        .signed_i  (signed_q),
        .rword_i   (mem_read_data),
        .wdata_i   (wdata_q),
        .ld_data_o (ld_data),
        .st_word_o (st_word)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        signed_d = signed_q;
        wdata_d  = wdata_q;
        merge_d  = merge_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        write_d  = write_q;
        case (state_q)
            S_IDLE: if (bus.req_valid) begin
                addr_d   = bus.req_addr;
                size_d   = bus.req_size;
                signed_d = bus.req_signed;
                wdata_d  = bus.req_wdata;
                write_d  = bus.req_write;
                err_d    = req_err;
                rdata_d  = '0;
                state_d  = req_err ? S_RESP :
                           !bus.req_write ? S_LOAD :
                           (bus.req_size == SZ_WORD) ? S_ST_WR : S_RMW_RD;
            end
            S_LOAD: begin
                rdata_d = ld_data;
                state_d = S_RESP;
            end
            S_RMW_RD: begin
                merge_d = st_word;
                state_d = S_RMW_WR;
            end
            S_RMW_WR, S_ST_WR: state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            size_q   <= SZ_BYTE;
            signed_q <= 1'b0;
            wdata_q  <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            write_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            wdata_q  <= wdata_d;
            merge_q  <= merge_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            write_q  <= write_d;
        end
    end

    assign bus.req_ready   = (state_q == S_IDLE);
    assign bus.resp_valid  = (state_q == S_RESP);
    assign bus.resp_err    = bus.resp_valid & err_q;
    // Stores never load rdata_q, but gating on write keeps the contract explicit.
    assign bus.resp_rdata  = (bus.resp_valid && !write_q) ? rdata_q : '0;
    assign mem_read        = (state_q == S_LOAD) || (state_q == S_RMW_RD);
    assign mem_write       = (state_q == S_RMW_WR) || (state_q == S_ST_WR);
    assign mem_address     = {addr_q[31:2], 2'b00};
    assign mem_write_data  = (state_q == S_ST_WR) ? wdata_q : merge_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized scoreboard bench against a byte-array memory model
module tb_load_store_unit;
    import lsu_pkg::*;

`ifdef LSU_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    typedef struct {
        bit          err;
        logic [31:0] rdata;
        int          lat;
        int          rd;
        int          wr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read, mem_write;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic [31:0] mem [4096];
    logic [7:0]  ref_mem [16384];
    exp_t        sb [$];
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    lsu_if bus ();

    load_store_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    assign mem_read_data = mem[mem_address[13:2]];
    always @(posedge clk) if (mem_write) mem[mem_address[13:2]] <= mem_write_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Byte-level reference: applies stores to ref_mem and predicts the response.
    task automatic model(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, output exp_t e);
        int n, base;
        logic [31:0] v;
        e.err = (sz == 2'b11) || (a >= 32'd16384) ||
                (ALIGN && ((sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)));
        e.rdata = 32'h0;
        e.lat = e.err ? 1 : (!w || sz == 2'b10) ? 2 : 3;
        e.rd = (e.err || (w && sz == 2'b10)) ? 0 : 1;
        e.wr = (!e.err && w) ? 1 : 0;
        if (!e.err) begin
            n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
            base = int'(a[13:0]) & ~(n - 1);
            if (w) begin
                for (int i = 0; i < n; i++) ref_mem[base + i] = wd[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[base + i];
                if (sg && n == 1 && v[7]) v[31:8] = '1;
                if (sg && n == 2 && v[15]) v[31:16] = '1;
                e.rdata = v;
            end
        end
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!bus.req_ready && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("req_ready_wait", {31'b0, bus.req_ready}, 32'd1);
    endtask

    task automatic drive(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        bus.req_write  = w;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        #1;
        // Scramble request fields after accept; the DUT must hold its captured copy.
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'($urandom);
        bus.req_size   = 2'($urandom);
        bus.req_signed = 1'($urandom);
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
    endtask

    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        wait_ready();
        model(w, sz, sg, a, wd, e);
        sb.push_back(e);
        drive(w, sz, sg, a, wd);
    endtask

    initial begin : monitor
        int cyc, rd, wr;
        bit busy;
        exp_t e;
        busy = 0; cyc = 0; rd = 0; wr = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy = 0;
                chk("rst_no_write", {31'b0, mem_write}, 32'd0);
            end else begin
                chk("rd_wr_excl", {31'b0, mem_read & mem_write}, 32'd0);
                if (busy) begin
                    cyc++;
                    rd += int'(mem_read);
                    wr += int'(mem_write);
                end else begin
                    chk("idle_no_mem", {31'b0, mem_read | mem_write}, 32'd0);
                end
                if (bus.resp_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_resp", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("resp_err", {31'b0, bus.resp_err}, {31'b0, e.err});
                        chk("resp_rdata", bus.resp_rdata, e.rdata);
                        chk("latency", cyc, e.lat);
                        chk("mem_reads", rd, e.rd);
                        chk("mem_writes", wr, e.wr);
                    end
                    busy = 0;
                end
                if (bus.req_valid && bus.req_ready) begin
                    busy = 1; cyc = 0; rd = 0; wr = 0;
                end
            end
        end
    end

    initial begin : stim
        logic [31:0] a, w;
        int bad;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        for (int i = 0; i < 4096; i++) begin
            w = $urandom;
            mem[i] = w;
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        chk("rst_resp_err", {31'b0, bus.resp_err}, 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_mem_rw", {30'b0, mem_read, mem_write}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF);
        issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
        issue(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h11223344);
        issue(1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h000000AA);
        issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
        issue(1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0);
        issue(1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0);
        issue(1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0);
        issue(1'b0, SZ_WORD, 1'b0, 32'h4000, 32'h0);
        issue(1'b1, SZ_WORD, 1'b0, 32'hFFFF_FFFC, 32'h55);
        issue(1'b0, SZ_HALF, 1'b1, 32'h13, 32'h0);
        issue(1'b0, SZ_RSVD, 1'b0, 32'h8, 32'h0);
        issue(1'b1, SZ_HALF, 1'b0, 32'h16, 32'h12348765);
        issue(1'b0, SZ_HALF, 1'b1, 32'h16, 32'h0);
        issue(1'b0, SZ_BYTE, 1'b1, 32'h3FFF, 32'h0);
        issue(1'b1, SZ_BYTE, 1'b0, 32'h3FFF, 32'h80);
        issue(1'b0, SZ_WORD, 1'b0, 32'h3FFC, 32'h0);

        // Reset while in RMW_RD: the write-back must never happen, no response.
        wait_ready();
        drive(1'b1, SZ_BYTE, 1'b0, 32'h21, 32'h5A);
        chk("rmw_rd_mem_read", {31'b0, mem_read}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_req_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("midrst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        chk("midrst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("midrst_mem_rw", {30'b0, mem_read, mem_write}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0);

        for (int i = 0; i < 300; i++) begin
            a = ($urandom_range(0, 9) == 0) ? $urandom_range(16384, 16400) : $urandom_range(0, 16383);
            if (i < 150) a = a & 32'h3F;
            issue(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
        end

        repeat (6) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 32'd0);
        bad = 0;
        for (int i = 0; i < 4096; i++)
            if (mem[i] !== {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]}) bad++;
        chk("mem_final_bad_words", bad, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
